// File: rtl/rx_ram_writer.sv
// Receive-side capture RAM: stores incoming words at an auto-incrementing address
// and offers a registered read port for readback and checking.
module rx_ram_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter bit WRAP       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  clear,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  overflow
);

    localparam int                  DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept;
    logic                  drop;
    logic [ADDR_WIDTH:0]   count_next;

    assign wr_ready = !clear && (WRAP || !full);
    assign accept   = wr_valid && wr_ready;
    // A word arriving while full is either lost (stop mode) or overwrites the oldest (circular).
    assign drop       = wr_valid && !clear && full;
    assign count_next = full ? count : count + (ADDR_WIDTH + 1)'(1);

    // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_addr  <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(1);
                count   <= count_next;
                full    <= (count_next == FULL_COUNT);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM; a write during reset is discarded.
    always_ff @(posedge clk) begin
        if (accept && rst_n) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Sampling mem on the same edge it is written gives the old word (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= rd;
            if (rd) begin
                q <= mem[rd_addr];
            end
        end
    end

endmodule
